// File: rtl/globals.sv
// Shared definitions for the weight path: tile geometry, RAM read latency,
// row type, tile feeder FSM states and the replay sideband record.
package globals;

  localparam int SZI               = 8;
  localparam int SZJ               = 8;
  localparam int ELM_W             = 8;
  localparam int TILEBUF_RDLATENCY = 2;

  typedef logic [SZJ*ELM_W-1:0] Bjvec;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } TileFeederState;

  // Per-row information travelling alongside the RAM read pipeline.
  typedef struct packed {
    logic valid;
    logic first;
    logic last_elm;
    logic end_row;
  } row_info_t;

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile RAM: one write port, one read port whose data
// emerges RD_LATENCY cycles after the address. Storage is not reset.
module tile_ram #(
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter int DW         = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] pipe [RD_LATENCY];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read followed by RD_LATENCY-1 delay stages.
  always_ff @(posedge clk) begin
    if (re) pipe[0] <= mem[raddr];
    for (int unsigned i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[RD_LATENCY-1];

endmodule

// File: rtl/weight_tile_feeder.sv
// Tile-granular weight buffer feeding the arith weight port. Holds up to
// NUM_TILES complete tiles and replays one tile of SZI rows per rdreq.
// Optional sticky protocol error output: WEIGHT_TILE_FEEDER_ERR_CHECK_EN.
module weight_tile_feeder #(
  parameter int SZI        = globals::SZI,
  parameter int SZJ        = globals::SZJ,
  parameter int ELM_W      = globals::ELM_W,
  parameter int NUM_TILES  = 4,
  parameter int RD_LATENCY = globals::TILEBUF_RDLATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [SZJ*ELM_W-1:0] wr_data,
  input  logic                 wr_layer_last,
  output logic                 wr_ready,
  input  logic                 rdreq,
  output logic                 rdready,
  output logic                 half_full,
  output logic [SZJ*ELM_W-1:0] q_value,
  output logic                 q_valid,
  output logic                 q_new_tile_k,
  output logic                 q_last_elm
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
  ,
  output logic                 err
`endif
);

  import globals::*;

  localparam int TW = $clog2(NUM_TILES);
  localparam int RW = $clog2(SZI);
  localparam int CW = TW + 1;
  localparam int AW = TW + RW;
  localparam int DW = SZJ * ELM_W;

  logic [RW-1:0]        wr_row;
  logic [TW-1:0]        wr_tile;
  logic [NUM_TILES-1:0] last_flag;
  logic [CW-1:0]        occ;
  logic [CW-1:0]        avail;

  TileFeederState       state, state_nxt;
  logic [RW-1:0]        rd_row, rd_row_nxt;
  logic [TW-1:0]        rd_tile, rd_tile_nxt;

  logic                 wr_fire, wr_done;
  logic                 rd_accept, rd_issue, rd_end, out_done;
  row_info_t            info_in;
  row_info_t            info_pipe [RD_LATENCY];
  logic [DW-1:0]        ram_q;

  assign wr_ready  = (occ != CW'(NUM_TILES));
  assign half_full = (occ >= CW'(NUM_TILES/2));
  assign wr_fire   = wr_valid & wr_ready;
  assign wr_done   = wr_fire & (wr_row == RW'(SZI-1));

  // Write row/tile pointers and per-tile layer-last flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row    <= '0;
      wr_tile   <= '0;
      last_flag <= '0;
    end else if (wr_fire) begin
      wr_row <= wr_row + RW'(1);
      if (wr_row == RW'(SZI-1)) begin
        last_flag[wr_tile] <= wr_layer_last;
        wr_tile            <= wr_tile + TW'(1);
      end
    end
  end

  // Tile occupancy (freed only once the final row has left the pipeline)
  // and availability (tiles complete but not yet started).
  always_ff @(posedge clk) begin
    if (reset) begin
      occ   <= '0;
      avail <= '0;
    end else begin
      occ   <= occ + CW'(wr_done) - CW'(out_done);
      avail <= avail + CW'(wr_done) - CW'(rd_accept);
    end
  end

  // Read FSM state and read pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_row  <= '0;
      rd_tile <= '0;
    end else begin
      state   <= state_nxt;
      rd_row  <= rd_row_nxt;
      rd_tile <= rd_tile_nxt;
    end
  end

  // Read FSM next state, address issue and sideband generation.
  always_comb begin
    state_nxt   = state;
    rd_row_nxt  = rd_row;
    rd_tile_nxt = rd_tile;
    rdready     = 1'b0;
    rd_accept   = 1'b0;
    rd_issue    = 1'b0;
    rd_end      = 1'b0;
    case (state)
      IDLE: begin
        rdready = (avail != '0);
        if (rdready && rdreq) begin
          rd_accept  = 1'b1;
          rd_row_nxt = '0;
          state_nxt  = READ;
        end
      end
      READ: begin
        rd_issue   = 1'b1;
        rd_end     = (rd_row == RW'(SZI-1));
        rd_row_nxt = rd_row + RW'(1);
        if (rd_end) begin
          rd_tile_nxt = rd_tile + TW'(1);
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    info_in.valid    = rd_issue;
    info_in.first    = rd_issue & (rd_row == '0);
    info_in.last_elm = rd_end & last_flag[rd_tile];
    info_in.end_row  = rd_end;
  end

  // Sideband pipeline matched to the RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) info_pipe[i] <= '0;
    end else begin
      info_pipe[0] <= info_in;
      for (int unsigned i = 1; i < RD_LATENCY; i++) info_pipe[i] <= info_pipe[i-1];
    end
  end

  tile_ram #(
    .DEPTH      (NUM_TILES * SZI),
    .AW         (AW),
    .DW         (DW),
    .RD_LATENCY (RD_LATENCY)
  ) u_tile_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_tile, wr_row}),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr ({rd_tile, rd_row}),
    .rdata (ram_q)
  );

  assign q_valid      = info_pipe[RD_LATENCY-1].valid;
  assign q_new_tile_k = info_pipe[RD_LATENCY-1].first;
  assign q_last_elm   = info_pipe[RD_LATENCY-1].last_elm;
  assign q_value      = q_valid ? ram_q : '0;
  assign out_done     = q_valid & info_pipe[RD_LATENCY-1].end_row;

`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
  // Sticky protocol error: read request while not ready or write while full.
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if ((rdreq & ~rdready) | (wr_valid & ~wr_ready)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_weight_tile_feeder.sv
// Self-checking bench for weight_tile_feeder against a queue-based model.
module tb_weight_tile_feeder;

  localparam int SZI = 8;
  localparam int NT  = 4;
  localparam int RDL = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic wr_valid = 1'b0, wr_layer_last = 1'b0, rdreq = 1'b0;
  globals::Bjvec wr_data = '0;
  globals::Bjvec q_value;
  logic wr_ready, rdready, half_full, q_valid, q_new_tile_k, q_last_elm;
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
  logic err;
`endif

  int n_checks = 0, n_pass = 0, cyc = 0;

  // Reference model: rows held per tile in FIFO order, outputs scheduled by cycle.
  globals::Bjvec cur_rows[$], done_rows[$], exp_val[$];
  bit done_flag[$], exp_last[$];
  int exp_cyc[$], exp_row[$];
  int m_occ = 0, rd_free = 0;
  bit m_err = 0;
  bit m_wr_ready, m_rdready, m_half, e_valid, e_first, e_last;
  globals::Bjvec e_value;

  always #5 clk = ~clk;

  weight_tile_feeder #(
    .SZI(SZI), .SZJ(8), .ELM_W(8), .NUM_TILES(NT), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_layer_last(wr_layer_last), .wr_ready(wr_ready), .rdreq(rdreq),
    .rdready(rdready), .half_full(half_full), .q_value(q_value),
    .q_valid(q_valid), .q_new_tile_k(q_new_tile_k), .q_last_elm(q_last_elm)
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
    , .err(err)
`endif
  );

  task automatic model_outputs();
    m_wr_ready = (m_occ != NT);
    m_half     = (m_occ >= NT/2);
    m_rdready  = (cyc >= rd_free) && (done_flag.size() > 0);
    e_valid    = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
    e_value    = e_valid ? exp_val[0] : '0;
    e_first    = e_valid && (exp_row[0] == 0);
    e_last     = e_valid && exp_last[0];
  endtask

  // Advance one clock and update the model from the inputs presented this cycle.
  task automatic step();
    bit wacc, racc, olast, errset, rst, ll, fl;
    globals::Bjvec d;
    rst    = reset;
    d      = wr_data;
    ll     = wr_layer_last;
    wacc   = !rst && wr_valid && m_wr_ready;
    racc   = !rst && rdreq && m_rdready;
    olast  = e_valid && (exp_row[0] == SZI-1);
    errset = (rdreq && !m_rdready) || (wr_valid && !m_wr_ready);
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      cur_rows.delete(); done_rows.delete(); done_flag.delete();
      exp_cyc.delete(); exp_val.delete(); exp_row.delete(); exp_last.delete();
      m_occ = 0; rd_free = 0; m_err = 0;
    end else begin
      if (errset) m_err = 1;
      if (wacc) begin
        cur_rows.push_back(d);
        if (cur_rows.size() == SZI) begin
          foreach (cur_rows[i]) done_rows.push_back(cur_rows[i]);
          done_flag.push_back(ll);
          cur_rows.delete();
          m_occ++;
        end
      end
      if (racc) begin
        fl = done_flag.pop_front();
        for (int i = 0; i < SZI; i++) begin
          exp_cyc.push_back(cyc + RDL + i);
          exp_val.push_back(done_rows.pop_front());
          exp_row.push_back(i);
          exp_last.push_back(fl && (i == SZI-1));
        end
        rd_free = cyc + SZI;
      end
      if (olast) m_occ--;
    end
    while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
      void'(exp_cyc.pop_front()); void'(exp_val.pop_front());
      void'(exp_row.pop_front()); void'(exp_last.pop_front());
    end
    model_outputs();
  endtask

  task automatic put_row(input globals::Bjvec d, input bit ll);
    wr_valid = 1; wr_data = d; wr_layer_last = ll;
    step();
    wr_valid = 0; wr_layer_last = 0;
  endtask

  task automatic pulse_rd();
    rdreq = 1;
    step();
    rdreq = 0;
  endtask

  function automatic globals::Bjvec rnd_row();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    reset = 1; step(); step(); reset = 0;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b exp 1", wr_ready); else n_pass++;
    n_checks++; if (rdready !== 1'b0) $display("FAIL reset_rdready got %b exp 0", rdready); else n_pass++;
    n_checks++; if (half_full !== 1'b0) $display("FAIL reset_half_full got %b exp 0", half_full); else n_pass++;
    n_checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid got %b exp 0", q_valid); else n_pass++;
    n_checks++; if (q_value !== '0) $display("FAIL reset_q_value got %h exp 0", q_value); else n_pass++;
    n_checks++; if ({q_new_tile_k, q_last_elm} !== 2'b00) $display("FAIL reset_q_flags got %b exp 00", {q_new_tile_k, q_last_elm}); else n_pass++;
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
`endif
  endtask

  task automatic test_single_tile();
    globals::Bjvec d;
    for (int i = 0; i < SZI; i++) begin
      d = rnd_row(); d[7:0] = 8'(i + 1);
      put_row(d, (i == SZI-1) ? 1'b0 : 1'($urandom_range(1)));
    end
    n_checks++; if (rdready !== 1'b1) $display("FAIL single_rdready got %b exp 1", rdready); else n_pass++;
    pulse_rd();
    for (int k = 1; k <= 12; k++) begin
      n_checks++; if (q_valid !== 1'((k >= 3) && (k <= 10))) $display("FAIL single_q_valid t+%0d got %b", k, q_valid); else n_pass++;
      if (k >= 3 && k <= 10) begin
        n_checks++; if (q_value[7:0] !== 8'(k - 2)) $display("FAIL single_lane0 t+%0d got %0d exp %0d", k, q_value[7:0], k - 2); else n_pass++;
        n_checks++; if (q_value !== e_value) $display("FAIL single_value t+%0d got %h exp %h", k, q_value, e_value); else n_pass++;
      end
      n_checks++; if (q_new_tile_k !== 1'(k == 3)) $display("FAIL single_new_tile t+%0d got %b", k, q_new_tile_k); else n_pass++;
      n_checks++; if (q_last_elm !== 1'b0) $display("FAIL single_last_elm t+%0d got %b exp 0", k, q_last_elm); else n_pass++;
      if (k <= 8) begin
        n_checks++; if (rdready !== 1'b0) $display("FAIL single_rdready_busy t+%0d got %b exp 0", k, rdready); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_fill();
    int n;
    for (int t = 0; t < NT; t++) begin
      for (int r = 0; r < SZI; r++) begin
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL fill_wr_ready tile %0d row %0d got 0 exp 1", t, r); else n_pass++;
        put_row(rnd_row(), 1'b0);
      end
      n_checks++; if (half_full !== 1'(t >= 1)) $display("FAIL fill_half_full after tile %0d got %b exp %b", t, half_full, t >= 1); else n_pass++;
    end
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL fill_full_wr_ready got %b exp 0", wr_ready); else n_pass++;
    put_row(rnd_row(), 1'b1);
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL fill_overflow_wr_ready got %b exp 0", wr_ready); else n_pass++;
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
    n_checks++; if (err !== 1'b1) $display("FAIL fill_overflow_err got %b exp 1", err); else n_pass++;
`endif
    pulse_rd();
    for (int k = 1; k <= 11; k++) begin
      n_checks++; if (q_valid !== 1'((k >= 3) && (k <= 10))) $display("FAIL fill_q_valid t+%0d got %b", k, q_valid); else n_pass++;
      n_checks++; if (q_value !== e_value) $display("FAIL fill_value t+%0d got %h exp %h", k, q_value, e_value); else n_pass++;
      n_checks++; if (wr_ready !== 1'(k >= 11)) $display("FAIL fill_wr_ready_return t+%0d got %b exp %b", k, wr_ready, k >= 11); else n_pass++;
      if (k < 11) step();
    end
    n = 0;
    while (n < 100 && (done_flag.size() > 0 || exp_cyc.size() > 0 || m_occ > 0)) begin
      rdreq = m_rdready; step(); rdreq = 0; n++;
      n_checks++; if ({q_valid, q_value} !== {e_valid, e_value}) $display("FAIL drain_row cyc %0d got %b/%h exp %b/%h", cyc, q_valid, q_value, e_valid, e_value); else n_pass++;
    end
    n_checks++; if (n >= 100) $display("FAIL drain_timeout got %0d cycles exp <100", n); else n_pass++;
    n_checks++; if ({half_full, wr_ready} !== 2'b01) $display("FAIL drain_status got %b exp 01", {half_full, wr_ready}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nvalid = 0, nlast = 0, last_idx = -1, a_last = -1, b_first = -1;
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < SZI; r++)
        put_row(rnd_row(), (r == SZI-1) ? 1'(t == 1) : 1'($urandom_range(1)));
    for (int k = 0; k < 30; k++) begin
      rdreq = m_rdready; step(); rdreq = 0;
      n_checks++; if ({q_valid, q_new_tile_k, q_last_elm, q_value} !== {e_valid, e_first, e_last, e_value})
        $display("FAIL b2b_row cyc %0d got %b%b%b/%h exp %b%b%b/%h", cyc, q_valid, q_new_tile_k, q_last_elm, q_value, e_valid, e_first, e_last, e_value);
      else n_pass++;
      if (q_valid === 1'b1) begin
        nvalid++;
        if (nvalid == SZI) a_last = cyc;
        if (nvalid == SZI + 1) b_first = cyc;
        if (q_last_elm === 1'b1) begin nlast++; last_idx = nvalid; end
      end
    end
    n_checks++; if (nvalid != 2*SZI) $display("FAIL b2b_row_count got %0d exp %0d", nvalid, 2*SZI); else n_pass++;
    n_checks++; if (nlast != 1 || last_idx != 2*SZI) $display("FAIL b2b_last_elm got count %0d at row %0d exp 1 at %0d", nlast, last_idx, 2*SZI); else n_pass++;
    n_checks++; if (b_first - a_last != 2) $display("FAIL b2b_gap got %0d exp 2", b_first - a_last); else n_pass++;
  endtask

  task automatic test_rdreq_empty();
    n_checks++; if (rdready !== 1'b0) $display("FAIL empty_rdready_pre got %b exp 0", rdready); else n_pass++;
    pulse_rd();
    for (int k = 1; k <= 12; k++) begin
      n_checks++; if ({q_valid, rdready} !== 2'b00) $display("FAIL empty_no_output t+%0d got %b exp 00", k, {q_valid, rdready}); else n_pass++;
      step();
    end
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
    n_checks++; if (err !== 1'b1) $display("FAIL empty_err got %b exp 1", err); else n_pass++;
`endif
    for (int r = 0; r < SZI; r++) put_row(rnd_row(), 1'b1);
    n_checks++; if (rdready !== 1'b1) $display("FAIL empty_rdready_after_write got %b exp 1", rdready); else n_pass++;
    pulse_rd();
    for (int k = 1; k <= 14; k++) begin
      n_checks++; if ({q_valid, q_last_elm, q_value} !== {e_valid, e_last, e_value}) $display("FAIL empty_read t+%0d got %b%b/%h exp %b%b/%h", k, q_valid, q_last_elm, q_value, e_valid, e_last, e_value); else n_pass++;
      step();
    end
    n_checks++; if (rdready !== 1'b0) $display("FAIL empty_rdready_final got %b exp 0", rdready); else n_pass++;
  endtask

  task automatic test_coincident();
    int n;
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < SZI; r++) put_row(rnd_row(), 1'b0);
    for (int r = 0; r < SZI-1; r++) put_row(rnd_row(), 1'b0);
    n_checks++; if (half_full !== 1'b1) $display("FAIL coin_half_full_pre got %b exp 1", half_full); else n_pass++;
    pulse_rd();
    for (int k = 1; k <= 12; k++) begin
      n_checks++; if ({half_full, wr_ready} !== 2'b11) $display("FAIL coin_status t+%0d got %b exp 11", k, {half_full, wr_ready}); else n_pass++;
      n_checks++; if ({q_valid, q_value} !== {e_valid, e_value}) $display("FAIL coin_row t+%0d got %b/%h exp %b/%h", k, q_valid, q_value, e_valid, e_value); else n_pass++;
      if (k == 10) put_row(rnd_row(), 1'b1);
      else step();
    end
    n = 0;
    while (n < 100 && (done_flag.size() > 0 || exp_cyc.size() > 0 || m_occ > 0)) begin
      rdreq = m_rdready; step(); rdreq = 0; n++;
      n_checks++; if ({q_valid, q_last_elm, q_value} !== {e_valid, e_last, e_value}) $display("FAIL coin_drain cyc %0d got %b%b/%h exp %b%b/%h", cyc, q_valid, q_last_elm, q_value, e_valid, e_last, e_value); else n_pass++;
    end
    n_checks++; if ({half_full, wr_ready, rdready} !== 3'b010) $display("FAIL coin_final_status got %b exp 010", {half_full, wr_ready, rdready}); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    for (int r = 0; r < SZI; r++) put_row(rnd_row(), 1'b0);
    pulse_rd();
    repeat (5) step();
    n_checks++; if ({q_valid, q_value} !== {1'b1, e_value}) $display("FAIL midrst_row4 got %b/%h exp 1/%h", q_valid, q_value, e_value); else n_pass++;
    reset = 1; step(); reset = 0;
    n_checks++; if ({q_valid, rdready, wr_ready, half_full} !== 4'b0010) $display("FAIL midrst_status got %b exp 0010", {q_valid, rdready, wr_ready, half_full}); else n_pass++;
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
    n_checks++; if (err !== 1'b0) $display("FAIL midrst_err got %b exp 0", err); else n_pass++;
`endif
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (q_valid !== 1'b0) $display("FAIL midrst_drop k=%0d got %b exp 0", k, q_valid); else n_pass++;
    end
    for (int r = 0; r < SZI; r++) put_row(rnd_row(), 1'b1);
    pulse_rd();
    for (int k = 1; k <= 12; k++) begin
      n_checks++; if ({q_valid, q_new_tile_k, q_last_elm, q_value} !== {e_valid, e_first, e_last, e_value})
        $display("FAIL midrst_roundtrip t+%0d got %b%b%b/%h exp %b%b%b/%h", k, q_valid, q_new_tile_k, q_last_elm, q_value, e_valid, e_first, e_last, e_value);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_random();
    int wp, rp;
    reset = 1; step(); reset = 0;
    for (int ph = 0; ph < 8; ph++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(5, 60);
      for (int k = 0; k < 100; k++) begin
        wr_valid = ($urandom_range(99) < wp);
        wr_data = rnd_row();
        wr_layer_last = 1'($urandom_range(1));
        rdreq = ($urandom_range(99) < rp);
        step();
        wr_valid = 0; rdreq = 0;
        n_checks++; if ({wr_ready, rdready, half_full} !== {m_wr_ready, m_rdready, m_half})
          $display("FAIL rnd_status cyc %0d got %b exp %b", cyc, {wr_ready, rdready, half_full}, {m_wr_ready, m_rdready, m_half});
        else n_pass++;
        n_checks++; if ({q_valid, q_new_tile_k, q_last_elm, q_value} !== {e_valid, e_first, e_last, e_value})
          $display("FAIL rnd_row cyc %0d got %b%b%b/%h exp %b%b%b/%h", cyc, q_valid, q_new_tile_k, q_last_elm, q_value, e_valid, e_first, e_last, e_value);
        else n_pass++;
`ifdef WEIGHT_TILE_FEEDER_ERR_CHECK_EN
        n_checks++; if (err !== m_err) $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, err, m_err); else n_pass++;
`endif
      end
    end
  endtask

  initial begin
    model_outputs();
    test_reset();
    test_single_tile();
    test_fill();
    test_back_to_back();
    test_rdreq_empty();
    test_coincident();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
